// File: rtl/hazard_scoreboard.sv
// In-order multi-issue RAW/WAW hazard scoreboard with a per-register latency countdown.
// Optional RAW stall performance counter is built when HAZARD_SB_PERF_EN is defined.
module hazard_scoreboard #(
  parameter int ISSUE_W = 2,
  parameter int LAT_W   = 3
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [ISSUE_W-1:0]       issue_valid,
  input  logic [5*ISSUE_W-1:0]     issue_rs,
  input  logic [5*ISSUE_W-1:0]     issue_rt,
  input  logic [ISSUE_W-1:0]       issue_read_rs,
  input  logic [ISSUE_W-1:0]       issue_read_rt,
  input  logic [5*ISSUE_W-1:0]     issue_rd,
  input  logic [ISSUE_W-1:0]       issue_wen,
  input  logic [LAT_W*ISSUE_W-1:0] issue_lat,
  input  logic                     pipe_stall,
  input  logic                     flush,
  output logic [ISSUE_W-1:0]       issue_accept,
  output logic [31:0]              busy_mask,
  output logic [31:0]              raw_stall_cycles
);

  logic [LAT_W-1:0] cnt     [32];
  logic [LAT_W-1:0] cnt_nxt [32];
  logic [4:0]       rs_a    [ISSUE_W];
  logic [4:0]       rt_a    [ISSUE_W];
  logic [4:0]       rd_a    [ISSUE_W];
  logic [LAT_W-1:0] lat_a   [ISSUE_W];
  logic [ISSUE_W-1:0] blocked;
  logic [ISSUE_W-1:0] ready;
  logic               prev_ok;

  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      rs_a[i]  = issue_rs[5*i +: 5];
      rt_a[i]  = issue_rt[5*i +: 5];
      rd_a[i]  = issue_rd[5*i +: 5];
      lat_a[i] = issue_lat[LAT_W*i +: LAT_W];
    end
  end

  // An operand is blocked by a pending producer or by an older writer in the same bundle.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (issue_read_rs[i] && rs_a[i] != 5'd0 && cnt[rs_a[i]] != '0) blocked[i] = 1'b1;
      if (issue_read_rt[i] && rt_a[i] != 5'd0 && cnt[rt_a[i]] != '0) blocked[i] = 1'b1;
      for (int j = 0; j < i; j++) begin
        if (issue_valid[j] && issue_wen[j] && rd_a[j] != 5'd0) begin
          if (issue_read_rs[i] && rd_a[j] == rs_a[i]) blocked[i] = 1'b1;
          if (issue_read_rt[i] && rd_a[j] == rt_a[i]) blocked[i] = 1'b1;
        end
      end
    end
  end

  // A younger slot can only issue when every older slot issued, keeping order strict.
  always_comb begin
    ready        = '0;
    issue_accept = '0;
    prev_ok      = 1'b1;
    for (int i = 0; i < ISSUE_W; i++) begin
      ready[i]        = issue_valid[i] & ~blocked[i] & prev_ok;
      issue_accept[i] = ready[i] & ~pipe_stall & ~flush & resetn;
      prev_ok         = issue_accept[i];
    end
  end

  // Later slots overwrite earlier ones, so the highest accepted writer wins.
  always_comb begin
    for (int r = 0; r < 32; r++) cnt_nxt[r] = cnt[r];
    if (flush) begin
      for (int r = 0; r < 32; r++) cnt_nxt[r] = '0;
    end else if (!pipe_stall) begin
      for (int r = 1; r < 32; r++)
        cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : '0;
      for (int i = 0; i < ISSUE_W; i++) begin
        if (issue_accept[i] && issue_wen[i] && rd_a[i] != 5'd0 && lat_a[i] != '0)
          cnt_nxt[rd_a[i]] = lat_a[i];
      end
    end
    cnt_nxt[0] = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < 32; r++) busy_mask[r] = (cnt[r] != '0);
  end

`ifdef HAZARD_SB_PERF_EN
  logic [31:0] raw_cnt;

  // Counts cycles where the oldest slot is held back only by a RAW hazard.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raw_cnt <= '0;
    end else if (issue_valid[0] && !ready[0] && !pipe_stall && !flush && raw_cnt != 32'hFFFF_FFFF) begin
      raw_cnt <= raw_cnt + 32'd1;
    end
  end

  assign raw_stall_cycles = raw_cnt;
`else
  assign raw_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (ISSUE_W=2, LAT_W=3).
// Perf counter expectations follow HAZARD_SB_PERF_EN when the bench is built with it.
module tb_hazard_scoreboard;

  localparam int ISSUE_W = 2;
  localparam int LAT_W   = 3;
`ifdef HAZARD_SB_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     resetn;
  logic [ISSUE_W-1:0]       issue_valid;
  logic [5*ISSUE_W-1:0]     issue_rs;
  logic [5*ISSUE_W-1:0]     issue_rt;
  logic [ISSUE_W-1:0]       issue_read_rs;
  logic [ISSUE_W-1:0]       issue_read_rt;
  logic [5*ISSUE_W-1:0]     issue_rd;
  logic [ISSUE_W-1:0]       issue_wen;
  logic [LAT_W*ISSUE_W-1:0] issue_lat;
  logic                     pipe_stall;
  logic                     flush;
  logic [ISSUE_W-1:0]       issue_accept;
  logic [31:0]              busy_mask;
  logic [31:0]              raw_stall_cycles;

  int check_count = 0;
  int error_count = 0;
  int exp_raw     = 0;

  hazard_scoreboard #(.ISSUE_W(ISSUE_W), .LAT_W(LAT_W)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .issue_valid      (issue_valid),
    .issue_rs         (issue_rs),
    .issue_rt         (issue_rt),
    .issue_read_rs    (issue_read_rs),
    .issue_read_rt    (issue_read_rt),
    .issue_rd         (issue_rd),
    .issue_wen        (issue_wen),
    .issue_lat        (issue_lat),
    .pipe_stall       (pipe_stall),
    .flush            (flush),
    .issue_accept     (issue_accept),
    .busy_mask        (busy_mask),
    .raw_stall_cycles (raw_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkRaw(input string tag);
    checkOutput(tag, raw_stall_cycles, PERF_ON ? 32'(exp_raw) : 32'd0);
  endtask

  task automatic clearStimulus();
    issue_valid   = '0;
    issue_rs      = '0;
    issue_rt      = '0;
    issue_read_rs = '0;
    issue_read_rt = '0;
    issue_rd      = '0;
    issue_wen     = '0;
    issue_lat     = '0;
    pipe_stall    = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic applyStimulus(input int slot, input logic v,
                               input logic [4:0] rs, input logic rrs,
                               input logic [4:0] rt, input logic rrt,
                               input logic [4:0] rd, input logic wen,
                               input logic [2:0] lat);
    issue_valid[slot]          = v;
    issue_rs[5*slot +: 5]      = rs;
    issue_read_rs[slot]        = rrs;
    issue_rt[5*slot +: 5]      = rt;
    issue_read_rt[slot]        = rrt;
    issue_rd[5*slot +: 5]      = rd;
    issue_wen[slot]            = wen;
    issue_lat[LAT_W*slot +: 3] = lat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    clearStimulus();
    applyStimulus(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    #2;
    checkOutput("reset_accept", issue_accept, 32'd0);
    checkOutput("reset_busy", busy_mask, 32'd0);
    checkRaw("reset_raw");
    tick();
    resetn = 1'b1;
    clearStimulus();
    tick();

    // Load-use: producer rd=5 lat=2, consumer waits two cycles
    applyStimulus(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd2);
    #1;
    checkOutput("lu_producer_accept", issue_accept, 32'd1);
    tick();
    clearStimulus();
    applyStimulus(0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    #1;
    checkOutput("lu_stall1_accept", issue_accept, 32'd0);
    checkOutput("lu_stall1_busy", busy_mask, 32'h0000_0020);
    tick();
    exp_raw++;
    checkOutput("lu_stall2_accept", issue_accept, 32'd0);
    checkOutput("lu_stall2_busy", busy_mask, 32'h0000_0020);
    tick();
    exp_raw++;
    checkOutput("lu_go_accept", issue_accept, 32'd1);
    checkOutput("lu_go_busy", busy_mask, 32'd0);
    checkRaw("lu_raw");
    tick();
    clearStimulus();

    // Intra-bundle RAW: slot1 reads slot0's rd
    applyStimulus(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd0);
    applyStimulus(1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 3'd0);
    #1;
    checkOutput("intra_accept", issue_accept, 32'd1);
    tick();
    checkOutput("intra_lat0_busy", busy_mask, 32'd0);
    clearStimulus();
    applyStimulus(0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 3'd0);
    #1;
    checkOutput("intra_reissue_accept", issue_accept, 32'd1);
    tick();
    clearStimulus();

    // Stall freeze: cnt[7]=3 held across four stalled cycles
    applyStimulus(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd3);
    tick();
    clearStimulus();
    pipe_stall = 1'b1;
    applyStimulus(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 3'd5);
    #1;
    checkOutput("stall_accept", issue_accept, 32'd0);
    for (int k = 0; k < 4; k++) tick();
    checkOutput("stall_hold_busy", busy_mask, 32'h0000_0080);
    clearStimulus();
    tick();
    checkOutput("stall_rel1_busy", busy_mask, 32'h0000_0080);
    tick();
    checkOutput("stall_rel2_busy", busy_mask, 32'h0000_0080);
    tick();
    checkOutput("stall_rel3_busy", busy_mask, 32'd0);

    // Flush with simultaneous issue, while another register is pending
    applyStimulus(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 3'd2);
    tick();
    clearStimulus();
    flush = 1'b1;
    applyStimulus(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd4);
    #1;
    checkOutput("flush_accept", issue_accept, 32'd0);
    tick();
    checkOutput("flush_busy", busy_mask, 32'd0);
    clearStimulus();

    // WAW in one bundle: highest slot wins (lat 5)
    applyStimulus(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd1);
    applyStimulus(1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd5);
    #1;
    checkOutput("waw_accept", issue_accept, 32'd3);
    tick();
    checkOutput("waw_busy", busy_mask, 32'h0000_0010);
    clearStimulus();
    applyStimulus(0, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    applyStimulus(1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    #1;
    checkOutput("inorder_accept", issue_accept, 32'd0);
    tick();
    exp_raw++;
    checkRaw("inorder_raw");
    clearStimulus();
    for (int k = 0; k < 3; k++) tick();
    checkOutput("waw_cnt1_busy", busy_mask, 32'h0000_0010);
    tick();
    checkOutput("waw_cnt0_busy", busy_mask, 32'd0);

    // WAW reversed: slot1 lat 1 overrides slot0 lat 5
    applyStimulus(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd5);
    applyStimulus(1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd1);
    tick();
    clearStimulus();
    checkOutput("waw_rev_busy1", busy_mask, 32'h0000_0010);
    tick();
    checkOutput("waw_rev_busy0", busy_mask, 32'd0);

    // Async reset mid-countdown
    applyStimulus(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 3'd3);
    tick();
    clearStimulus();
    checkOutput("ares_pre_busy", busy_mask, 32'h0000_0100);
    #2;
    resetn = 1'b0;
    exp_raw = 0;
    #1;
    checkOutput("ares_busy", busy_mask, 32'd0);
    checkRaw("ares_raw");
    #2;
    resetn = 1'b1;
    tick();
    checkOutput("ares_after_busy", busy_mask, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
